lane_ram_ctrl: RTL and testbench

LANE_RAM_CTRL -- requirements
Module: lane_ram_ctrl

---
 rtl/lane_ram_ctrl.sv | 134 +++++++++++++
 tb/tb_lane_ram_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_ram_ctrl.sv
// Byte-laned scratch RAM behind a valid/ready request/response port.
// Loads and stores of 1..LANES bytes, natural alignment enforced, one-cycle response.
module lane_ram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LANES      = 4,
  localparam int DATA_WIDTH = 8 * LANES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [15:0]           err_count
);

  localparam int LANE_BITS = $clog2(LANES);
  localparam int ROWS      = (2 ** ADDR_WIDTH) / LANES;

  // Handshake: a beat transfers on any edge where valid && ready are both high.
  // Request side may be accepted while a response is being consumed in the same cycle.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic                              accept;
  logic [3:0]                        size_bytes;
  logic                              size_err;
  logic                              align_err;
  logic                              acc_err;
  logic [LANE_BITS-1:0]              lane;
  logic [ADDR_WIDTH-LANE_BITS-1:0]   row;

  logic [7:0]                        bank_mem [LANES][ROWS];
  logic [LANES-1:0]                  bank_we;
  logic [7:0]                        bank_wbyte [LANES];
  logic [LANE_BITS-1:0]              wr_off [LANES];
  logic [LANE_BITS-1:0]              rd_bank [LANES];
  logic [7:0]                        rd_byte [LANES];
  logic                              sign_bit;
  logic [DATA_WIDTH-1:0]             load_data;

  assign req_ready = !rst && (state == IDLE || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  assign size_bytes = 4'd1 << req_size;
  assign size_err   = (req_size == 2'b11 && LANES < 8) || (int'(size_bytes) > LANES);
  assign align_err  = (req_addr & ADDR_WIDTH'(size_bytes - 4'd1)) != '0;
  assign acc_err    = size_err || align_err;

  assign lane = req_addr[LANE_BITS-1:0];
  assign row  = req_addr[ADDR_WIDTH-1:LANE_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = RESP;
    end else if (state == RESP && rsp_ready) begin
      state_next = IDLE;
    end
  end

  // Each bank sees the store byte whose offset from the start lane lands on it.
  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      wr_off[b]     = LANE_BITS'(b) - lane;
      bank_we[b]    = accept && req_write && !acc_err && (int'(wr_off[b]) < int'(size_bytes));
      bank_wbyte[b] = req_wdata[8*wr_off[b] +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (bank_we[b]) begin
        bank_mem[b][row] <= bank_wbyte[b];
      end
    end
  end

  // Aligned legal accesses never wrap past the last lane, so one row serves all banks.
  always_comb begin
    sign_bit  = 1'b0;
    load_data = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_bank[k] = lane + LANE_BITS'(k);
      rd_byte[k] = bank_mem[rd_bank[k]][row];
      if (k == int'(size_bytes) - 1) begin
        sign_bit = rd_byte[k][7];
      end
    end
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(size_bytes)) begin
        load_data[8*k +: 8] = rd_byte[k];
      end else begin
        load_data[8*k +: 8] = {8{req_signed & sign_bit}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else if (accept) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || req_write) ? '0 : load_data;
      if (acc_err && err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lane_ram_ctrl.sv
// Bench for lane_ram_ctrl: directed vector table, randomized traffic against a
// flat byte-array model, backpressure/reset sequences, and an 8-lane instance.
module tb_lane_ram_ctrl;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] err_count;

  logic        req_valid8, req_ready8, req_write8, req_signed8;
  logic [1:0]  req_size8;
  logic [9:0]  req_addr8;
  logic [63:0] req_wdata8;
  logic        rsp_valid8, rsp_ready8, rsp_err8;
  logic [63:0] rsp_rdata8;
  logic [15:0] err_count8;

  lane_ram_ctrl #(.ADDR_WIDTH(10), .LANES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_count(err_count)
  );

  lane_ram_ctrl #(.ADDR_WIDTH(10), .LANES(8)) dut8 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid8), .req_ready(req_ready8), .req_write(req_write8),
    .req_size(req_size8), .req_signed(req_signed8), .req_addr(req_addr8),
    .req_wdata(req_wdata8), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8),
    .rsp_rdata(rsp_rdata8), .rsp_err(rsp_err8), .err_count(err_count8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flat byte-addressed memory, alignment and size rules by arithmetic.
  logic [7:0] model_mem [1024];
  int         model_errs = 0;

  task automatic model_access(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [9:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err);
    int nb;
    longint unsigned val;
    nb  = 1 << sz;
    err = (nb > 4) || ((int'(addr) % nb) != 0);
    rd  = '0;
    if (err) begin
      if (model_errs < 65535) model_errs++;
    end else if (wr) begin
      for (int k = 0; k < nb; k++) model_mem[int'(addr) + k] = 8'(wd >> (8 * k));
    end else begin
      val = 0;
      for (int k = 0; k < nb; k++) val |= longint'(model_mem[int'(addr) + k]) << (8 * k);
      if (sg && val[8*nb-1]) val |= ~((64'd1 << (8 * nb)) - 64'd1);
      rd = val[31:0];
    end
  endtask

  // One accepted request; returns with outputs of that request's response visible.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [9:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    #1 check("req_ready_on_issue", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rsp_valid_after_accept", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic issue8(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [9:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err, input logic [15:0] exp_cnt);
    req_valid8 = 1'b1; req_write8 = wr; req_size8 = sz; req_signed8 = sg;
    req_addr8 = addr; req_wdata8 = wd;
    @(posedge clk); #1;
    req_valid8 = 1'b0;
    check("l8_rsp_valid", {63'd0, rsp_valid8}, 64'd1);
    check("l8_rdata", rsp_rdata8, exp_rd);
    check("l8_err", {63'd0, rsp_err8}, {63'd0, exp_err});
    check("l8_err_count", {48'd0, err_count8}, {48'd0, exp_cnt});
  endtask

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [31:0] m_rd, m_rd2, hold_rd;
    logic        m_err;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic [9:0]  addr;
    logic        wr, sg;

    vecs[0]  = '{1'b1, SZ_W, 1'b0, 10'h000, 32'h11223344, 32'h0,        1'b0, 16'd0};
    vecs[1]  = '{1'b1, SZ_W, 1'b0, 10'h010, 32'h8899AABB, 32'h0,        1'b0, 16'd0};
    vecs[2]  = '{1'b0, SZ_B, 1'b1, 10'h013, 32'h0,        32'hFFFFFF88, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, SZ_B, 1'b0, 10'h013, 32'h0,        32'h00000088, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, SZ_H, 1'b0, 10'h012, 32'hCAFE1234, 32'h0,        1'b0, 16'd0};
    vecs[5]  = '{1'b0, SZ_W, 1'b0, 10'h010, 32'h0,        32'h1234AABB, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, SZ_H, 1'b0, 10'h011, 32'h0,        32'h0,        1'b1, 16'd1};
    vecs[7]  = '{1'b1, SZ_W, 1'b0, 10'h002, 32'hDEADBEEF, 32'h0,        1'b1, 16'd2};
    vecs[8]  = '{1'b0, SZ_W, 1'b0, 10'h000, 32'h0,        32'h11223344, 1'b0, 16'd2};
    vecs[9]  = '{1'b0, SZ_H, 1'b1, 10'h010, 32'h0,        32'hFFFFAABB, 1'b0, 16'd2};
    vecs[10] = '{1'b0, SZ_H, 1'b1, 10'h012, 32'h0,        32'h00001234, 1'b0, 16'd2};
    vecs[11] = '{1'b0, SZ_D, 1'b0, 10'h010, 32'h0,        32'h0,        1'b1, 16'd3};
    vecs[12] = '{1'b1, SZ_B, 1'b0, 10'h011, 32'hFFFFFF5A, 32'h0,        1'b0, 16'd3};
    vecs[13] = '{1'b0, SZ_W, 1'b0, 10'h010, 32'h0,        32'h12345ABB, 1'b0, 16'd3};
    vecs[14] = '{1'b0, SZ_B, 1'b1, 10'h011, 32'h0,        32'h0000005A, 1'b0, 16'd3};
    vecs[15] = '{1'b0, SZ_W, 1'b0, 10'h012, 32'h0,        32'h0,        1'b1, 16'd4};
    vecs[16] = '{1'b1, SZ_W, 1'b0, 10'h011, 32'h00000000, 32'h0,        1'b1, 16'd5};
    vecs[17] = '{1'b0, SZ_W, 1'b0, 10'h010, 32'h0,        32'h12345ABB, 1'b0, 16'd5};
    vecs[18] = '{1'b0, SZ_B, 1'b1, 10'h010, 32'h0,        32'hFFFFFFBB, 1'b0, 16'd5};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    req_valid8 = 1'b0; req_write8 = 1'b0; req_size8 = '0; req_signed8 = 1'b0;
    req_addr8 = '0; req_wdata8 = '0; rsp_ready8 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_err_count", {48'd0, err_count}, 64'd0);
    rst = 1'b0;
    #1 check("idle_req_ready", {63'd0, req_ready}, 64'd1);

    // Known contents for the random region 0x000..0x03F
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model_access(1'b1, SZ_W, 1'b0, 10'(i * 4), wd, m_rd, m_err);
      issue(1'b1, SZ_W, 1'b0, 10'(i * 4), wd);
      check("fill_err", {63'd0, rsp_err}, 64'd0);
    end

    // Directed vector table, back-to-back
    for (int i = 0; i < 19; i++) begin
      model_access(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd, m_rd, m_err);
      issue(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d_rdata", i), {32'd0, rsp_rdata}, {32'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_err", i), {63'd0, rsp_err}, {63'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_err_count", i), {48'd0, err_count}, {48'd0, vecs[i].exp_cnt});
    end

    // Random traffic vs model, with occasional bubbles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        check("bubble_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      end else begin
        wr   = 1'($urandom_range(0, 1));
        sz   = 2'($urandom_range(0, 3));
        sg   = 1'($urandom_range(0, 1));
        addr = 10'($urandom_range(0, 63));
        wd   = $urandom;
        model_access(wr, sz, sg, addr, wd, m_rd, m_err);
        issue(wr, sz, sg, addr, wd);
        check("rand_rdata", {32'd0, rsp_rdata}, {32'd0, m_rd});
        check("rand_err", {63'd0, rsp_err}, {63'd0, m_err});
        check("rand_err_count", {48'd0, err_count}, 64'(model_errs));
      end
    end

    // Backpressure: response held 3 cycles, then consumed together with a new accept
    @(posedge clk); #1;
    model_access(1'b0, SZ_W, 1'b0, 10'h010, 32'h0, m_rd, m_err);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_W; req_signed = 1'b0; req_addr = 10'h010;
    #1 check("bp_first_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    hold_rd = rsp_rdata;
    check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("bp_rdata", {32'd0, rsp_rdata}, {32'd0, m_rd});
    req_addr = 10'h000;
    for (int c = 0; c < 3; c++) begin
      check("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
      check("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_hold_rdata", {32'd0, rsp_rdata}, {32'd0, m_rd});
      check("bp_hold_err", {63'd0, rsp_err}, 64'd0);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", {63'd0, req_ready}, 64'd1);
    model_access(1'b0, SZ_W, 1'b0, 10'h000, 32'h0, m_rd2, m_err);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_new_valid", {63'd0, rsp_valid}, 64'd1);
    check("bp_new_rdata", {32'd0, rsp_rdata}, {32'd0, m_rd2});

    // Reset with a pending response; a store presented during reset is dropped
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", {63'd0, rsp_valid}, 64'd1);
    check("pre_rst_err_count", {63'd0, (err_count != 16'd0)}, 64'd1);
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_W; req_addr = 10'h010; req_wdata = 32'hFFFFFFFF;
    #1 check("rst_blocks_ready", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    check("rst_drop_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_clear_err_count", {48'd0, err_count}, 64'd0);
    check("rst_clear_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_clear_err", {63'd0, rsp_err}, 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; model_errs = 0;
    @(posedge clk); #1;
    model_access(1'b0, SZ_W, 1'b0, 10'h010, 32'h0, m_rd, m_err);
    issue(1'b0, SZ_W, 1'b0, 10'h010, 32'h0);
    check("rst_mem_unchanged", {32'd0, rsp_rdata}, {32'd0, m_rd});
    check("post_rst_err_count", {48'd0, err_count}, 64'd0);

    // Eight-lane instance
    issue8(1'b1, SZ_D, 1'b0, 10'h008, 64'h0123456789ABCDEF, 64'h0, 1'b0, 16'd0);
    issue8(1'b0, SZ_D, 1'b0, 10'h008, 64'h0, 64'h0123456789ABCDEF, 1'b0, 16'd0);
    issue8(1'b0, SZ_W, 1'b1, 10'h00C, 64'h0, 64'h0000000001234567, 1'b0, 16'd0);
    issue8(1'b0, SZ_B, 1'b1, 10'h008, 64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0, 16'd0);
    issue8(1'b0, SZ_H, 1'b1, 10'h00E, 64'h0, 64'h0000000000000123, 1'b0, 16'd0);
    issue8(1'b0, SZ_D, 1'b0, 10'h004, 64'h0, 64'h0, 1'b1, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
